sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
- Central arbiter and command sequencer for the single-chip SDRAM controller.
- Holds the command/address bus for the init block until power-up completes. Then it grants the bus to one of three requesters: refresh, write or read.
- Muxes the granted requester's registered cmd/addr/bank onto the SDRAM pins. Owners sequence ACT/RD/WR/PRE themselves.
- Refresh has absolute priority. Write and read alternate round-robin when both are pending. A watchdog reclaims the bus from a hung owner.

Parameters:
ADDR_W, 13, SDRAM address width
BA_W, 2, bank address width
NOP_CMD, 4'b0111, {cs_n,ras_n,cas_n,we_n} idle command
TIMEOUT, 1023, max cycles any single grant may last before forced release

Ports:
sysclk_100M  in  1  100 MHz system clock
rst_n  in  1  asynchronous active-low reset
init_done  in  1  level, high once init sequence finished
init_cmd  in  4  init block command
init_addr  in  ADDR_W  init block address
ref_req  in  1  level, held by refresh block until ack
ref_ack  out  1  one-cycle grant pulse
ref_end  in  1  one-cycle pulse, refresh (incl. tRFC) done
ref_cmd  in  4  / ref_addr  in  ADDR_W  refresh block bus
wr_req  in  1  level, held until ack
wr_ack  out  1  one-cycle grant pulse
wr_end  in  1  level, write session complete
wr_prech_end  in  1  one-cycle pulse after each write-side precharge
wr_cmd  in  4  / wr_addr  in  ADDR_W  / wr_bank  in  BA_W  write block bus
rd_req, rd_ack, rd_end, rd_prech_end, rd_cmd, rd_addr, rd_bank  read block, same meaning/widths as write
sdram_cmd  out  4  to pins
sdram_addr  out  ADDR_W  to pins
sdram_bank  out  BA_W  to pins
timeout_err  out  1  sticky, set on watchdog expiry

Behaviour:
- Reset values:
  - state = S_INIT
  - all acks 0; timeout_err 0
  - last_grant = READ, so write wins the first tie
  - watchdog = 0
- States are one-hot: S_INIT, S_ARBIT, S_REF, S_WRITE, S_READ.
- S_INIT:
  - bus = init_cmd/init_addr, bank 0
  - -> S_ARBIT on first cycle init_done = 1
  - req inputs ignored
- S_ARBIT:
  - bus = NOP_CMD, addr 0, bank 0
  - Priority 1: ref_req -> S_REF, pulse ref_ack
  - Priority 2: wr_req && !rd_req -> S_WRITE, pulse wr_ack
  - Priority 3: rd_req && !wr_req -> S_READ, pulse rd_ack
  - Both wr_req and rd_req -> grant the one not equal to last_grant
  - Ack is registered: high exactly one cycle, the first cycle of the new state. No ack fires in any other state.
- S_REF:
  - bus = ref_cmd/ref_addr, bank 0
  - -> S_ARBIT on ref_end
- S_WRITE:
  - bus = wr_cmd/wr_addr/wr_bank
  - Stays while the owner re-activates rows.
  - -> S_ARBIT on wr_prech_end && (wr_end || ref_req)
  - On exit, last_grant <= WRITE.
- S_READ:
  - Same as S_WRITE using rd_* signals.
  - On exit, last_grant <= READ.
- Bus mux is combinational from the state register: zero added latency. Owner outputs are already registered.
- Watchdog:
  - Counter clears on every state change and increments in S_REF/S_WRITE/S_READ.
  - On reaching TIMEOUT: force -> S_ARBIT, drive NOP, set timeout_err.
  - timeout_err is cleared only by reset.
- Simultaneous events:
  - ref_end together with a new ref_req: return to S_ARBIT first; re-grant refresh next cycle.
  - prech_end in the same cycle as a watchdog expiry: watchdog path taken, err set.
- Reset mid-grant: returns to S_INIT immediately, bus = init_cmd. init_done must re-qualify.
- End/prech_end pulses arriving in a non-matching state are ignored.

Decomposition:
- Shared package sdram_pkg holds:
  - command encodings: NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001, MRS 0000
  - one-hot state constants
  - owner enum {INIT, REF, WRITE, READ}
  - ADDR_W/BA_W defaults
- One natural sub-module: sdram_bus_mux, a combinational 4:1 mux of cmd/addr/bank selected by owner. Watchdog and FSM stay in the top.

Test Plan:
- Hold init_done = 0 for 200 cycles with init_cmd = 4'b0010 -> sdram_cmd = 0010 throughout; no acks. Raise init_done -> next cycle state S_ARBIT, sdram_cmd = 0111.
- ref_req, wr_req and rd_req all raised in the same cycle -> ref_ack pulses 1 cycle first. After ref_end -> wr_ack. After write releases -> rd_ack.
- Read session with rd_end = 0 and rd_prech_end pulsed 3 times, no ref_req -> grant kept, rd_cmd passed through. Then assert ref_req before the next rd_prech_end -> exit to S_ARBIT, ref_ack next cycle.
- wr_req and rd_req held continuously -> grants alternate W, R, W, R over 4 sessions.
- Grant write and never send wr_prech_end -> exactly 1023 cycles later bus = NOP, state S_ARBIT, timeout_err = 1, stays 1.
- Assert rst_n low mid-read -> sdram_cmd = init_cmd, rd_ack = 0, timeout_err = 0 asynchronously.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: command encodings, arbiter
// states and bus-owner identifiers.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 13;
    localparam int SDRAM_BA_W   = 2;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_ARBIT = 5'b00010,
        S_REF   = 5'b00100,
        S_WRITE = 5'b01000,
        S_READ  = 5'b10000
    } state_e;

    typedef enum logic [1:0] {
        OWN_INIT  = 2'd0,
        OWN_REF   = 2'd1,
        OWN_WRITE = 2'd2,
        OWN_READ  = 2'd3
    } owner_e;

endpackage

// File: rtl/sdram_bus_mux.sv
// Combinational selection of the owning requester's cmd/addr/bank onto the
// SDRAM pins; drives NOP with zero address/bank while the bus is idle.
module sdram_bus_mux
    import sdram_pkg::*;
#(
    parameter int         ADDR_W  = SDRAM_ADDR_W,
    parameter int         BA_W    = SDRAM_BA_W,
    parameter logic [3:0] NOP_CMD = CMD_NOP
) (
    input  logic [1:0]        owner_i,
    input  logic              idle_i,
    input  logic [3:0]        init_cmd_i,
    input  logic [ADDR_W-1:0] init_addr_i,
    input  logic [3:0]        ref_cmd_i,
    input  logic [ADDR_W-1:0] ref_addr_i,
    input  logic [3:0]        wr_cmd_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [BA_W-1:0]   wr_bank_i,
    input  logic [3:0]        rd_cmd_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [BA_W-1:0]   rd_bank_i,
    output logic [3:0]        cmd_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [BA_W-1:0]   bank_o
);

    always_comb begin
        // NOTE: every output is given a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        cmd_o  = NOP_CMD;
        addr_o = '0;
        bank_o = '0;
        if (!idle_i) begin
            case (owner_e'(owner_i))
                OWN_INIT: begin
                    cmd_o  = init_cmd_i;
                    addr_o = init_addr_i;
                end
                OWN_REF: begin
                    cmd_o  = ref_cmd_i;
                    addr_o = ref_addr_i;
                end
                OWN_WRITE: begin
                    cmd_o  = wr_cmd_i;
                    addr_o = wr_addr_i;
                    bank_o = wr_bank_i;
                end
                OWN_READ: begin
                    cmd_o  = rd_cmd_i;
                    addr_o = rd_addr_i;
                    bank_o = rd_bank_i;
                end
            endcase
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Central SDRAM command-bus arbiter: holds the bus for init, then grants it to
// refresh (absolute priority) or write/read (round-robin), with a grant watchdog.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int         ADDR_W  = SDRAM_ADDR_W,
    parameter int         BA_W    = SDRAM_BA_W,
    parameter logic [3:0] NOP_CMD = CMD_NOP,
    parameter int         TIMEOUT = 1023
) (
    input  logic              sysclk_100M,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              ref_req,
    output logic              ref_ack,
    input  logic              ref_end,
    input  logic [3:0]        ref_cmd,
    input  logic [ADDR_W-1:0] ref_addr,
    input  logic              wr_req,
    output logic              wr_ack,
    input  logic              wr_end,
    input  logic              wr_prech_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BA_W-1:0]   wr_bank,
    input  logic              rd_req,
    output logic              rd_ack,
    input  logic              rd_end,
    input  logic              rd_prech_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BA_W-1:0]   rd_bank,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BA_W-1:0]   sdram_bank,
    output logic              timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    owner_e          last_grant_q, last_grant_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            ref_ack_q, ref_ack_d;
    logic            wr_ack_q, wr_ack_d;
    logic            rd_ack_q, rd_ack_d;
    logic            timeout_err_q, timeout_err_d;
    logic            granted;
    logic            wd_expired;
    owner_e          bus_owner;
    logic            bus_idle;

    assign granted    = state_q inside {S_REF, S_WRITE, S_READ};
    // A grant lasts at most TIMEOUT cycles: expiry fires in its last cycle.
    assign wd_expired = granted && (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge sysclk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_INIT;
            last_grant_q  <= OWN_READ;
            wd_q          <= '0;
            ref_ack_q     <= 1'b0;
            wr_ack_q      <= 1'b0;
            rd_ack_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            wd_q          <= wd_d;
            ref_ack_q     <= ref_ack_d;
            wr_ack_q      <= wr_ack_d;
            rd_ack_q      <= rd_ack_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        ref_ack_d     = 1'b0;
        wr_ack_d      = 1'b0;
        rd_ack_d      = 1'b0;
        timeout_err_d = timeout_err_q;

        case (state_q)
            S_INIT: begin
                if (init_done) state_d = S_ARBIT;
            end
            S_ARBIT: begin
                if (ref_req) begin
                    state_d   = S_REF;
                    ref_ack_d = 1'b1;
                end else if (wr_req && (!rd_req || last_grant_q == OWN_READ)) begin
                    state_d  = S_WRITE;
                    wr_ack_d = 1'b1;
                end else if (rd_req) begin
                    state_d  = S_READ;
                    rd_ack_d = 1'b1;
                end
            end
            S_REF: begin
                if (ref_end) state_d = S_ARBIT;
            end
            S_WRITE: begin
                if (wd_expired || (wr_prech_end && (wr_end || ref_req))) begin
                    state_d      = S_ARBIT;
                    last_grant_d = OWN_WRITE;
                end
            end
            S_READ: begin
                if (wd_expired || (rd_prech_end && (rd_end || ref_req))) begin
                    state_d      = S_ARBIT;
                    last_grant_d = OWN_READ;
                end
            end
            default: state_d = S_INIT;
        endcase

        // Watchdog outranks any end/prech_end arriving in the same cycle.
        if (wd_expired) begin
            state_d       = S_ARBIT;
            timeout_err_d = 1'b1;
        end

        if (state_d != state_q || !granted) wd_d = '0;
        else                                wd_d = wd_q + 1'b1;
    end

    always_comb begin
        bus_owner = OWN_INIT;
        bus_idle  = 1'b0;
        case (state_q)
            S_INIT:  bus_owner = OWN_INIT;
            S_REF:   bus_owner = OWN_REF;
            S_WRITE: bus_owner = OWN_WRITE;
            S_READ:  bus_owner = OWN_READ;
            default: bus_idle  = 1'b1;
        endcase
    end

    sdram_bus_mux #(
        .ADDR_W  (ADDR_W),
        .BA_W    (BA_W),
        .NOP_CMD (NOP_CMD)
    ) u_bus_mux (
        .owner_i     (bus_owner),
        .idle_i      (bus_idle),
        .init_cmd_i  (init_cmd),
        .init_addr_i (init_addr),
        .ref_cmd_i   (ref_cmd),
        .ref_addr_i  (ref_addr),
        .wr_cmd_i    (wr_cmd),
        .wr_addr_i   (wr_addr),
        .wr_bank_i   (wr_bank),
        .rd_cmd_i    (rd_cmd),
        .rd_addr_i   (rd_addr),
        .rd_bank_i   (rd_bank),
        .cmd_o       (sdram_cmd),
        .addr_o      (sdram_addr),
        .bank_o      (sdram_bank)
    );

    assign ref_ack     = ref_ack_q;
    assign wr_ack      = wr_ack_q;
    assign rd_ack      = rd_ack_q;
    assign timeout_err = timeout_err_q;

endmodule
